dequant_stream: RTL and testbench

Parametrised, pipelined successor to the combinational block dequantiser. It multiplies each row of an 8x8 coefficient block by the matching row of a runtime-loadable quantisation table, then saturates the result to the output width. It sits between the Huffman/RLE decode stage and the IDCT and streams one 8-coefficient row per cycle under valid/ready flow control. Tables and the channel-to-table map are written through a side port while the block is idle.

---
 rtl/dequant_stream.sv | 174 +++++++++++++++++
 tb/tb_dequant_stream.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dequant_stream.sv
// Streaming 8x8 block dequantiser: multiplies each coefficient row by the matching
// row of a runtime-loadable quant table, then saturates to OW bits (2-stage pipeline).
module dequant_stream #(
  parameter int CW   = 12,
  parameter int QW   = 8,
  parameter int OW   = 12,
  parameter int NTAB = 4,
  parameter int CH   = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [8*CW-1:0]           in_row,
  input  logic [$clog2(CH+1)-1:0]   in_ch,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [8*OW-1:0]           out_row,
  output logic [$clog2(CH+1)-1:0]   out_ch,
  output logic [2:0]                out_row_idx,
  output logic                      out_last,
  output logic                      out_sat,
  input  logic                      tab_wr_en,
  input  logic [$clog2(NTAB)-1:0]   tab_wr_sel,
  input  logic [5:0]                tab_wr_idx,
  input  logic [QW-1:0]             tab_wr_data,
  input  logic                      map_wr_en,
  input  logic [$clog2(CH+1)-1:0]   map_wr_ch,
  input  logic [$clog2(NTAB)-1:0]   map_wr_sel,
  output logic                      cfg_ready
);

  localparam int CHW = $clog2(CH + 1);
  localparam int TW  = $clog2(NTAB);
  localparam int PW  = CW + QW + 1;
  localparam logic signed [PW-1:0] PMAX = PW'(2 ** (OW - 1) - 1);
  localparam logic signed [PW-1:0] PMIN = PW'(-(2 ** (OW - 1)));

  logic [QW-1:0]      tab_q [NTAB][64];
  // Sized to cover every in_ch code; entries >= CH are never written, so they select table 0.
  logic [TW-1:0]      map_q [2**CHW];

  logic [2:0]         row_cnt;
  logic [CHW-1:0]     blk_ch;
  logic [TW-1:0]      blk_tab;

  logic               s1_valid;
  logic [8*CW-1:0]    s1_row;
  logic [2:0]         s1_idx;
  logic [CHW-1:0]     s1_ch;
  logic [8*QW-1:0]    s1_q;

  logic               s1_load, s2_load, in_fire;
  logic [CHW-1:0]     cur_ch;
  logic [TW-1:0]      cur_tab;
  logic [8*QW-1:0]    cur_q;

  logic signed [PW-1:0] prod;
  logic [8*OW-1:0]    sat_row;
  logic [7:0]         sat_lane;

  assign s2_load   = !out_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign in_fire   = in_valid && s1_load;
  assign cfg_ready = (row_cnt == 3'd0) && !s1_valid && !out_valid && !in_valid;

  // Row 0 resolves channel and table live; later rows reuse the values latched on row 0.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cur_ch  = blk_ch;
    cur_tab = blk_tab;
    cur_q   = '0;
    if (row_cnt == 3'd0) begin
      cur_ch  = in_ch;
      cur_tab = map_q[in_ch];
    end
    for (int c = 0; c < 8; c++) begin
      cur_q[c*QW +: QW] = tab_q[cur_tab][{row_cnt, 3'(c)}];
    end
  end

  // NOTE: the tables are flop arrays, not RAM, so they can (and must) reset to identity.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < NTAB; t++) begin
        for (int i = 0; i < 64; i++) begin
          tab_q[t][i] <= QW'(1);
        end
      end
      for (int i = 0; i < 2**CHW; i++) begin
        map_q[i] <= '0;
      end
    end else begin
      if (tab_wr_en && cfg_ready) begin
        tab_q[tab_wr_sel][tab_wr_idx] <= tab_wr_data;
      end
      if (map_wr_en && cfg_ready && (map_wr_ch < CHW'(CH))) begin
        map_q[map_wr_ch] <= map_wr_sel;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_cnt  <= 3'd0;
      blk_ch   <= '0;
      blk_tab  <= '0;
      s1_valid <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
      end
      if (in_fire) begin
        row_cnt <= row_cnt + 3'd1;
        if (row_cnt == 3'd0) begin
          blk_ch  <= in_ch;
          blk_tab <= cur_tab;
        end
      end
    end
  end

  // Stage-1 payload is qualified by s1_valid, so it carries no reset.
  always_ff @(posedge clock) begin
    if (in_fire) begin
      s1_row <= in_row;
      s1_idx <= row_cnt;
      s1_ch  <= cur_ch;
      s1_q   <= cur_q;
    end
  end

  // Signed coefficient times zero-extended quant entry cannot overflow CW+QW+1 bits.
  always_comb begin
    prod     = '0;
    sat_row  = '0;
    sat_lane = '0;
    for (int c = 0; c < 8; c++) begin
      prod = PW'($signed(s1_row[c*CW +: CW])) * PW'($signed({1'b0, s1_q[c*QW +: QW]}));
      if (prod > PMAX) begin
        sat_row[c*OW +: OW] = PMAX[OW-1:0];
        sat_lane[c]         = 1'b1;
      end else if (prod < PMIN) begin
        sat_row[c*OW +: OW] = PMIN[OW-1:0];
        sat_lane[c]         = 1'b1;
      end else begin
        sat_row[c*OW +: OW] = prod[OW-1:0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_row     <= '0;
      out_ch      <= '0;
      out_row_idx <= 3'd0;
      out_last    <= 1'b0;
      out_sat     <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_row     <= sat_row;
        out_ch      <= s1_ch;
        out_row_idx <= s1_idx;
        out_last    <= (s1_idx == 3'd7);
        out_sat     <= |sat_lane;
      end
    end
  end

endmodule

// File: tb/tb_dequant_stream.sv
// Directed self-checking bench for dequant_stream: expected rows are queued per beat
// and compared on every output handshake.
module tb_dequant_stream;

  typedef int row_t [8];

  typedef struct {
    logic [95:0] row;
    logic [1:0]  ch;
    logic [2:0]  idx;
    logic        last;
    logic        sat;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        in_valid, in_ready;
  logic [95:0] in_row;
  logic [1:0]  in_ch;
  logic        out_valid, out_ready;
  logic [95:0] out_row;
  logic [1:0]  out_ch;
  logic [2:0]  out_row_idx;
  logic        out_last, out_sat;
  logic        tab_wr_en;
  logic [1:0]  tab_wr_sel;
  logic [5:0]  tab_wr_idx;
  logic [7:0]  tab_wr_data;
  logic        map_wr_en;
  logic [1:0]  map_wr_ch;
  logic [1:0]  map_wr_sel;
  logic        cfg_ready;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  int   occ      = 0;
  bit   bp_mode  = 0;
  bit   bp_check = 0;
  int   cyc      = 0;

  dequant_stream dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_row      (in_row),
    .in_ch       (in_ch),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_ch      (out_ch),
    .out_row_idx (out_row_idx),
    .out_last    (out_last),
    .out_sat     (out_sat),
    .tab_wr_en   (tab_wr_en),
    .tab_wr_sel  (tab_wr_sel),
    .tab_wr_idx  (tab_wr_idx),
    .tab_wr_data (tab_wr_data),
    .map_wr_en   (map_wr_en),
    .map_wr_ch   (map_wr_ch),
    .map_wr_sel  (map_wr_sel),
    .cfg_ready   (cfg_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] pack(input row_t v);
    logic [95:0] p;
    p = '0;
    for (int c = 0; c < 8; c++) p[c*12 +: 12] = 12'(v[c]);
    return p;
  endfunction

  // Downstream ready: always high, or 1-on/2-off during the backpressure test.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      out_ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
      cyc++;
    end
  end

  // Output scoreboard and in_ready occupancy check, sampled mid-cycle.
  always @(negedge clock) begin
    if (reset) begin
      occ = 0;
    end else begin
      if (bp_check)
        check("in_ready_vs_occupancy", 128'(in_ready), 128'((occ < 2) || out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 128'(out_valid), 128'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_row", 128'(out_row), 128'(e.row));
          check("out_row_idx", 128'(out_row_idx), 128'(e.idx));
          check("out_ch", 128'(out_ch), 128'(e.ch));
          check("out_last", 128'(out_last), 128'(e.last));
          check("out_sat", 128'(out_sat), 128'(e.sat));
        end
      end
      occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
    end
  end

  // Drives one beat and returns just after the edge that accepted it.
  task automatic send_beat(input row_t coef, input int ch, input row_t exp_v,
                           input int idx, input bit sat);
    exp_t e;
    bit   got;
    int   n;
    e.row  = pack(exp_v);
    e.ch   = 2'(ch);
    e.idx  = 3'(idx);
    e.last = (idx == 7);
    e.sat  = sat;
    exp_q.push_back(e);
    in_valid = 1'b1;
    in_row   = pack(coef);
    in_ch    = 2'(ch);
    got = 0;
    n   = 0;
    while (!got && n < 1000) begin
      @(negedge clock);
      got = in_ready;
      @(posedge clock);
      #1;
      n++;
    end
    if (!got) check("beat_accept_timeout", 128'(got), 128'(1));
  endtask

  task automatic drain();
    for (int n = 0; n < 500 && (exp_q.size() != 0 || out_valid); n++) begin
      @(posedge clock);
      #1;
    end
    check("drain_queue_empty", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic write_tab(input int sel, input int idx, input int data);
    tab_wr_en   = 1'b1;
    tab_wr_sel  = 2'(sel);
    tab_wr_idx  = 6'(idx);
    tab_wr_data = 8'(data);
    @(posedge clock);
    #1;
    tab_wr_en = 1'b0;
  endtask

  task automatic write_map(input int ch, input int sel);
    map_wr_en  = 1'b1;
    map_wr_ch  = 2'(ch);
    map_wr_sel = 2'(sel);
    @(posedge clock);
    #1;
    map_wr_en = 1'b0;
  endtask

  // One block of all-ones rows on ch: table 1 holds idx+1, so lane value = 8r+c+1.
  task automatic send_ones_rows(input int ch, input int r_lo, input int r_hi);
    row_t ones, ev;
    ones = '{1, 1, 1, 1, 1, 1, 1, 1};
    for (int r = r_lo; r <= r_hi; r++) begin
      for (int c = 0; c < 8; c++) ev[c] = 8 * r + c + 1;
      send_beat(ones, ch, ev, r, 1'b0);
    end
  endtask

  initial begin
    row_t v, z, ev, cv;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_row      = '0;
    in_ch       = '0;
    tab_wr_en   = 1'b0;
    tab_wr_sel  = '0;
    tab_wr_idx  = '0;
    tab_wr_data = '0;
    map_wr_en   = 1'b0;
    map_wr_ch   = '0;
    map_wr_sel  = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_row", 128'(out_row), 128'(0));
    check("rst_out_ch", 128'(out_ch), 128'(0));
    check("rst_out_row_idx", 128'(out_row_idx), 128'(0));
    check("rst_out_last", 128'(out_last), 128'(0));
    check("rst_out_sat", 128'(out_sat), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_cfg_ready", 128'(cfg_ready), 128'(1));
    @(posedge clock);
    #1;

    // Identity tables pass coefficients through, with two-cycle latency.
    v = '{1, -1, 2047, -2048, 0, 5, -5, 100};
    z = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_beat(v, 0, v, 0, 1'b0);
    in_valid = 1'b0;
    check("lat_not_before_2", 128'(out_valid), 128'(0));
    @(posedge clock);
    #1;
    check("lat_valid_at_2", 128'(out_valid), 128'(1));
    check("lat_row_at_2", 128'(out_row), 128'(pack(v)));
    for (int r = 1; r < 8; r++) send_beat(z, 0, z, r, 1'b0);
    in_valid = 1'b0;
    drain();

    // Table 1 = idx+1, ch2 -> table 1.
    check("cfg_ready_idle", 128'(cfg_ready), 128'(1));
    for (int i = 0; i < 64; i++) write_tab(1, i, i + 1);
    write_map(2, 1);
    send_ones_rows(2, 0, 7);
    in_valid = 1'b0;
    drain();

    // Saturation: table 2 = 255 everywhere, ch0 -> table 2.
    for (int i = 0; i < 64; i++) write_tab(2, i, 255);
    write_map(0, 2);
    v  = '{100, -100, 8, -8, 0, 1, -1, 2};
    ev = '{2047, -2048, 2040, -2040, 0, 255, -255, 510};
    send_beat(v, 0, ev, 0, 1'b1);
    v  = '{8, 8, 8, 8, 8, 8, 8, 8};
    ev = '{2040, 2040, 2040, 2040, 2040, 2040, 2040, 2040};
    for (int r = 1; r < 8; r++) send_beat(v, 0, ev, r, 1'b0);
    // Channel code 3 (>= CH) falls back to table 0 (identity).
    v = '{7, 7, 7, 7, 7, 7, 7, 7};
    for (int r = 0; r < 8; r++) send_beat(v, 3, v, r, 1'b0);
    in_valid = 1'b0;
    drain();

    // Backpressure: two back-to-back blocks on ch2 with out_ready 1-on/2-off.
    bp_mode  = 1;
    bp_check = 1;
    for (int b = 0; b < 2; b++) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          cv[c] = c - 3 + b;
          ev[c] = (c - 3 + b) * (8 * r + c + 1);
        end
        send_beat(cv, 2, ev, r, 1'b0);
      end
    end
    in_valid = 1'b0;
    drain();
    bp_check = 0;
    bp_mode  = 0;
    repeat (3) @(posedge clock);
    #1;

    // Config writes while a block is in flight are dropped.
    send_ones_rows(2, 0, 3);
    in_valid = 1'b0;
    check("cfg_ready_busy", 128'(cfg_ready), 128'(0));
    tab_wr_en   = 1'b1;
    tab_wr_sel  = 2'd1;
    tab_wr_idx  = 6'd0;
    tab_wr_data = 8'd0;
    map_wr_en   = 1'b1;
    map_wr_ch   = 2'd2;
    map_wr_sel  = 2'd0;
    @(posedge clock);
    #1;
    tab_wr_en = 1'b0;
    map_wr_en = 1'b0;
    send_ones_rows(2, 4, 7);
    in_valid = 1'b0;
    drain();
    check("cfg_ready_after_drain", 128'(cfg_ready), 128'(1));
    send_ones_rows(2, 0, 7);
    in_valid = 1'b0;
    drain();

    // Reset mid-block after row 4 is accepted.
    send_ones_rows(2, 0, 4);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) cv[c] = 10 * r + c - 20;
      send_beat(cv, 1, cv, r, 1'b0);
    end
    in_valid = 1'b0;
    drain();

    check("final_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
